// File: rtl/mult_fu.sv
// Pipelined integer multiply unit: one partial-product slice per stage, results held for the CDB.
// Mispredict squash clears stages whose ROB tag falls in the circular (branch, tail] window.
module mult_fu #(
  parameter int XLEN      = 32,
  parameter int STAGES    = 4,
  parameter int ROB_TAG_W = 5,
  parameter int RS_TAG_W  = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [XLEN-1:0]      rs1_value,
  input  logic [XLEN-1:0]      rs2_value,
  input  logic [1:0]           mult_func,
  input  logic [ROB_TAG_W-1:0] rob_tag,
  input  logic [RS_TAG_W-1:0]  rs_id,
  output logic                 fu_done_valid,
  output logic [RS_TAG_W-1:0]  fu_done_id,
  input  logic                 mispredict,
  input  logic [ROB_TAG_W-1:0] branch_rob_tag,
  input  logic [ROB_TAG_W-1:0] rob_tail,
  output logic                 done_valid,
  output logic [XLEN-1:0]      done_value,
  output logic [ROB_TAG_W-1:0] done_rob_tag,
  input  logic                 cdb_grant
);

  localparam int DW = 2 * XLEN;
  localparam int C  = DW / STAGES;

  logic [STAGES-1:0]    valid_q, valid_d;
  logic [ROB_TAG_W-1:0] tag_q  [STAGES];
  logic [ROB_TAG_W-1:0] tag_d  [STAGES];
  logic [1:0]           func_q [STAGES];
  logic [1:0]           func_d [STAGES];
  logic [DW-1:0]        a_q    [STAGES];
  logic [DW-1:0]        a_d    [STAGES];
  logic [DW-1:0]        b_q    [STAGES];
  logic [DW-1:0]        b_d    [STAGES];
  logic [DW-1:0]        acc_q  [STAGES];
  logic [DW-1:0]        acc_d  [STAGES];

  logic [STAGES-1:0] free;
  logic              accept;
  logic [DW-1:0]     a_ext, b_ext;

  function automatic logic in_window(input logic [ROB_TAG_W-1:0] x,
                                     input logic [ROB_TAG_W-1:0] b,
                                     input logic [ROB_TAG_W-1:0] t);
    if (b <= t) return (x > b) && (x <= t);
    else        return (x > b) || (x <= t);
  endfunction

  assign a_ext = (mult_func == 2'd3) ? {{XLEN{1'b0}}, rs1_value}
                                     : {{XLEN{rs1_value[XLEN-1]}}, rs1_value};
  assign b_ext = mult_func[1] ? {{XLEN{1'b0}}, rs2_value}
                              : {{XLEN{rs2_value[XLEN-1]}}, rs2_value};

  // A stage frees when it is empty or everything downstream of it drains this edge.
  always_comb begin
    logic f;
    free = '0;
    f = !valid_q[STAGES-1] || cdb_grant;
    free[STAGES-1] = f;
    for (int k = STAGES - 2; k >= 0; k--) begin
      f = !valid_q[k] || f;
      free[k] = f;
    end
  end

  assign issue_ready   = free[0];
  assign accept        = issue_valid && issue_ready;
  assign fu_done_valid = accept;
  assign fu_done_id    = accept ? rs_id : '0;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    func_d  = func_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    for (int k = STAGES - 1; k >= 1; k--) begin
      if (free[k]) begin
        valid_d[k] = valid_q[k-1];
        tag_d[k]   = tag_q[k-1];
        func_d[k]  = func_q[k-1];
        a_d[k]     = a_q[k-1];
        b_d[k]     = b_q[k-1];
        acc_d[k]   = acc_q[k-1] + ((a_q[k-1] * DW'(b_q[k-1][k*C +: C])) << (k * C));
      end
    end
    if (free[0]) begin
      valid_d[0] = accept;
      tag_d[0]   = rob_tag;
      func_d[0]  = mult_func;
      a_d[0]     = a_ext;
      b_d[0]     = b_ext;
      acc_d[0]   = a_ext * DW'(b_ext[C-1:0]);
    end
    // Squash wins over advance; a squashed issue still lands in stage 0, just invalid.
    for (int k = 0; k < STAGES; k++) begin
      if (mispredict && in_window(tag_d[k], branch_rob_tag, rob_tail)) valid_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        tag_q[k]  <= '0;
        func_q[k] <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        acc_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      func_q  <= func_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign done_valid   = valid_q[STAGES-1] &&
                        !(mispredict && in_window(tag_q[STAGES-1], branch_rob_tag, rob_tail));
  assign done_rob_tag = tag_q[STAGES-1];
  assign done_value   = (func_q[STAGES-1] == 2'd0) ? acc_q[STAGES-1][XLEN-1:0]
                                                   : acc_q[STAGES-1][DW-1:XLEN];

endmodule

// File: tb/tb_mult_fu.sv
// Bench for mult_fu: directed scenarios plus random traffic against a queue-based
// model that tracks each in-flight result's pipeline position and reference product.
module tb_mult_fu;
  localparam int XLEN   = 32;
  localparam int STAGES = 4;
  localparam int TW     = 5;
  localparam int RW     = 3;

  logic            clock, reset_n;
  logic            issue_valid, issue_ready;
  logic [XLEN-1:0] rs1_value, rs2_value;
  logic [1:0]      mult_func;
  logic [TW-1:0]   rob_tag;
  logic [RW-1:0]   rs_id;
  logic            fu_done_valid;
  logic [RW-1:0]   fu_done_id;
  logic            mispredict;
  logic [TW-1:0]   branch_rob_tag, rob_tail;
  logic            done_valid;
  logic [XLEN-1:0] done_value;
  logic [TW-1:0]   done_rob_tag;
  logic            cdb_grant;

  mult_fu #(.XLEN(XLEN), .STAGES(STAGES), .ROB_TAG_W(TW), .RS_TAG_W(RW)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .mult_func(mult_func),
    .rob_tag(rob_tag), .rs_id(rs_id),
    .fu_done_valid(fu_done_valid), .fu_done_id(fu_done_id),
    .mispredict(mispredict), .branch_rob_tag(branch_rob_tag), .rob_tail(rob_tail),
    .done_valid(done_valid), .done_value(done_value), .done_rob_tag(done_rob_tag),
    .cdb_grant(cdb_grant)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [TW-1:0]   tag;
    logic [XLEN-1:0] val;
    int              pos;
  } ent_t;

  ent_t            exp_q[$];
  logic [XLEN-1:0] got_val[$];
  logic [TW-1:0]   got_tag[$];
  int              total = 0;
  int              bad   = 0;
  bit              acc_flag;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic bit win(input logic [TW-1:0] x, input logic [TW-1:0] b, input logic [TW-1:0] t);
    if (b <= t) return (x > b) && (x <= t);
    return (x > b) || (x <= t);
  endfunction

  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] f, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    longint      sa, sb, su;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    su = longint'({32'h0, b});
    case (f)
      2'd0:    p = sa * sb;
      2'd1:    p = sa * sb;
      2'd2:    p = sa * su;
      default: p = {32'h0, a} * {32'h0, b};
    endcase
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [XLEN-1:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // driver tasks
  task automatic set_issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                           input logic [TW-1:0] tag, input logic [RW-1:0] id);
    issue_valid = 1'b1;
    rs1_value   = a;
    rs2_value   = b;
    mult_func   = f;
    rob_tag     = tag;
    rs_id       = id;
  endtask

  task automatic no_issue();
    issue_valid = 1'b0;
  endtask

  // One clock cycle: check mid-cycle against the model, then advance model and clock.
  task automatic cycle(output bit accepted);
    bit   exp_ready, acc, at_out, exp_dv;
    int   lim;
    ent_t e;
    ent_t nq[$];
    @(negedge clock);
    exp_ready = cdb_grant || (exp_q.size() < STAGES);
    check("issue_ready", 64'(issue_ready), 64'(exp_ready));
    acc = issue_valid && exp_ready;
    check("fu_done_valid", 64'(fu_done_valid), 64'(acc));
    check("fu_done_id", 64'(fu_done_id), acc ? 64'(rs_id) : 64'd0);
    at_out = (exp_q.size() > 0) && (exp_q[0].pos == STAGES - 1);
    exp_dv = at_out && !(mispredict && win(exp_q[0].tag, branch_rob_tag, rob_tail));
    check("done_valid", 64'(done_valid), 64'(exp_dv));
    if (exp_dv) begin
      check("done_value", 64'(done_value), 64'(exp_q[0].val));
      check("done_rob_tag", 64'(done_rob_tag), 64'(exp_q[0].tag));
      if (cdb_grant) begin
        got_val.push_back(done_value);
        got_tag.push_back(done_rob_tag);
      end
    end
    if (at_out && cdb_grant) void'(exp_q.pop_front());
    // each result slides forward one stage until it sits right behind the one ahead
    lim = STAGES;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].pos + 1 < lim - 1) exp_q[i].pos = exp_q[i].pos + 1;
      else                            exp_q[i].pos = lim - 1;
      lim = exp_q[i].pos;
    end
    if (mispredict) begin
      nq.delete();
      foreach (exp_q[i]) if (!win(exp_q[i].tag, branch_rob_tag, rob_tail)) nq.push_back(exp_q[i]);
      exp_q = nq;
    end
    if (acc && !(mispredict && win(rob_tag, branch_rob_tag, rob_tail))) begin
      e.tag = rob_tag;
      e.val = ref_mul(mult_func, rs1_value, rs2_value);
      e.pos = 0;
      exp_q.push_back(e);
    end
    accepted = acc;
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int n);
    bit a;
    no_issue();
    cdb_grant  = 1'b1;
    mispredict = 1'b0;
    repeat (n) cycle(a);
  endtask

  logic [XLEN-1:0] fc_a[4], fc_b[4], fc_exp[4];
  logic [1:0]      fc_f[4];
  logic [TW-1:0]   sq_tags[4];
  int              nxt;

  initial begin
    reset_n = 1'b0; issue_valid = 1'b0; rs1_value = '0; rs2_value = '0; mult_func = '0;
    rob_tag = '0; rs_id = '0; mispredict = 1'b0; branch_rob_tag = '0; rob_tail = '0;
    cdb_grant = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_issue_ready", 64'(issue_ready), 64'd1);
    check("rst_fu_done_valid", 64'(fu_done_valid), 64'd0);
    check("rst_fu_done_id", 64'(fu_done_id), 64'd0);
    check("rst_done_valid", 64'(done_valid), 64'd0);
    check("rst_done_value", 64'(done_value), 64'd0);
    check("rst_done_rob_tag", 64'(done_rob_tag), 64'd0);
    reset_n = 1'b1;

    // basic latency: MUL 7x6, tag 3, rs_id 5
    cdb_grant = 1'b1;
    set_issue(32'd7, 32'd6, 2'd0, 5'd3, 3'd5);
    #1;
    check("basic_fu_valid", 64'(fu_done_valid), 64'd1);
    check("basic_fu_id", 64'(fu_done_id), 64'd5);
    cycle(acc_flag);
    no_issue();
    repeat (3) cycle(acc_flag);
    check("basic_done_valid", 64'(done_valid), 64'd1);
    check("basic_done_value", 64'(done_value), 64'd42);
    check("basic_done_tag", 64'(done_rob_tag), 64'd3);
    drain(3);

    // function coverage
    fc_f   = '{2'd1, 2'd3, 2'd2, 2'd0};
    fc_a   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    fc_b   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
    fc_exp = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    got_val.delete(); got_tag.delete();
    for (int i = 0; i < 4; i++) begin
      set_issue(fc_a[i], fc_b[i], fc_f[i], 5'(10 + i), 3'(i));
      cycle(acc_flag);
    end
    drain(8);
    check("func_count", 64'(got_val.size()), 64'd4);
    if (got_val.size() == 4)
      for (int i = 0; i < 4; i++) check("func_value", 64'(got_val[i]), 64'(fc_exp[i]));

    // backpressure: tags 1..6, grant low for 7 cycles
    got_val.delete(); got_tag.delete();
    nxt = 1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      cdb_grant = (cyc >= 7);
      if (nxt <= 6) set_issue($urandom, $urandom, 2'd0, 5'(nxt), 3'(nxt));
      else          no_issue();
      #1;
      if (cyc == 4) check("bp_ready_low", 64'(issue_ready), 64'd0);
      cycle(acc_flag);
      if (acc_flag) nxt++;
    end
    check("bp_count", 64'(got_tag.size()), 64'd6);
    if (got_tag.size() == 6)
      for (int i = 0; i < 6; i++) check("bp_order", 64'(got_tag[i]), 64'(i + 1));

    // squash without wrap: in flight 4, 6, 9; b=5 t=9; tag 7 issued alongside
    got_val.delete(); got_tag.delete();
    cdb_grant = 1'b0;
    sq_tags = '{5'd4, 5'd6, 5'd9, 5'd0};
    for (int i = 0; i < 3; i++) begin
      set_issue($urandom, $urandom, 2'd0, sq_tags[i], 3'(i));
      cycle(acc_flag);
    end
    set_issue(32'd5, 32'd5, 2'd0, 5'd7, 3'd2);
    mispredict = 1'b1; branch_rob_tag = 5'd5; rob_tail = 5'd9;
    #1;
    check("sq_fu_valid", 64'(fu_done_valid), 64'd1);
    cycle(acc_flag);
    drain(10);
    check("sq_count", 64'(got_tag.size()), 64'd1);
    if (got_tag.size() == 1) check("sq_survivor", 64'(got_tag[0]), 64'd4);

    // squash with wrap: in flight 13, 15, 0, 2; b=14 t=2
    got_val.delete(); got_tag.delete();
    cdb_grant = 1'b0;
    sq_tags = '{5'd13, 5'd15, 5'd0, 5'd2};
    for (int i = 0; i < 4; i++) begin
      set_issue($urandom, $urandom, 2'($urandom_range(0, 3)), sq_tags[i], 3'(i));
      cycle(acc_flag);
    end
    no_issue();
    mispredict = 1'b1; branch_rob_tag = 5'd14; rob_tail = 5'd2;
    cycle(acc_flag);
    drain(10);
    check("wrap_count", 64'(got_tag.size()), 64'd1);
    if (got_tag.size() == 1) check("wrap_survivor", 64'(got_tag[0]), 64'd13);

    // asynchronous reset with three results in flight
    cdb_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_issue($urandom, $urandom, 2'd0, 5'(20 + i), 3'(i));
      cycle(acc_flag);
    end
    no_issue();
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_done_valid", 64'(done_valid), 64'd0);
    check("mid_rst_done_value", 64'(done_value), 64'd0);
    check("mid_rst_done_tag", 64'(done_rob_tag), 64'd0);
    check("mid_rst_ready", 64'(issue_ready), 64'd1);
    check("mid_rst_fu_valid", 64'(fu_done_valid), 64'd0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cdb_grant = 1'b1;
    set_issue(32'd3, 32'd3, 2'd0, 5'd8, 3'd1);
    cycle(acc_flag);
    no_issue();
    repeat (3) cycle(acc_flag);
    check("post_rst_valid", 64'(done_valid), 64'd1);
    check("post_rst_value", 64'(done_value), 64'd9);
    check("post_rst_tag", 64'(done_rob_tag), 64'd8);
    drain(3);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 2) != 0)
        set_issue(rand_op(), rand_op(), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  3'($urandom_range(0, 7)));
      else
        no_issue();
      cdb_grant      = ($urandom_range(0, 9) < 7);
      mispredict     = ($urandom_range(0, 19) == 0);
      branch_rob_tag = 5'($urandom_range(0, 31));
      rob_tail       = 5'($urandom_range(0, 31));
      cycle(acc_flag);
    end
    drain(10);
    check("final_idle", 64'(done_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_fu.md
# mult_fu

Pipelined integer multiply functional unit that sits directly downstream of the reservation station. It consumes the operand bundle of an issued MULT reservation-station entry and signals back which RS entry may be freed. It produces a `rob_tag`/value result toward the CDB and holds that result until the CDB grants it. It supports mispredict squash using the same circular ROB-window rule as the RS.

## Interface
- `XLEN`, default 32: operand/result width.
- `STAGES`, default 4: pipeline depth. Must be 1, 2, 4 or 8, so that it divides 2·XLEN.
- `ROB_TAG_W`, default 5: ROB tag width.
- `RS_TAG_W`, default 3: RS entry index width.
- `clock`, in, 1: single clock. All state is updated on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `issue_valid`, in, 1: the RS entry's `issue_valid`, meaning both operands are ready.
- `issue_ready`, out, 1: the unit can accept an issue this cycle.
- `rs1_value`, `rs2_value`, in, XLEN each: operands.
- `mult_func`, in, 2: 0 = MUL, 1 = MULH, 2 = MULHSU, 3 = MULHU.
- `rob_tag`, in, ROB_TAG_W: destination ROB tag.
- `rs_id`, in, RS_TAG_W: index of the issuing RS entry.
- `fu_done_valid`, out, 1: asserted for one cycle when an issue is accepted.
- `fu_done_id`, out, RS_TAG_W: RS index to free.
- `mispredict`, in, 1: branch mispredict squash request.
- `branch_rob_tag`, in, ROB_TAG_W: tag of the mispredicted branch.
- `rob_tail`, in, ROB_TAG_W: current ROB tail tag.
- `done_valid`, out, 1: a result is pending for the CDB.
- `done_value`, out, XLEN: the result.
- `done_rob_tag`, out, ROB_TAG_W: tag of the result.
- `cdb_grant`, in, 1: the CDB consumes the result at this edge. Only meaningful while `done_valid` is high.

## Operation
- **Operand extension.** Operands are extended to 2·XLEN:
  - a: sign-extended for funcs 0, 1, 2; zero-extended for func 3.
  - b: sign-extended for funcs 0, 1; zero-extended for funcs 2, 3.
- **Pipeline contents.** Stage k (k = 0..STAGES-1) is a register holding `valid`, `rob_tag`, `mult_func`, a_ext, b_ext and `acc` (2·XLEN).
- **Accumulation.** Let C = 2·XLEN/STAGES.
  - On entry to stage 0: `acc` = a_ext · b_ext[C-1:0].
  - On moving from stage k-1 to stage k: `acc` += (a_ext · b_ext[kC+C-1:kC]) << kC.
  - All sums are taken mod 2^(2·XLEN). No rounding or saturation.
- **Result select.** The result is taken from the last stage: func 0 gives `acc[XLEN-1:0]`; funcs 1–3 give `acc[2·XLEN-1:XLEN]`.
- **Advance rule (bubble-collapsing).** The last stage frees when it is empty or `cdb_grant` is high. Stage k advances when stage k+1 frees. An empty stage always accepts.
- **Issue handshake.** `issue_ready` = stage 0 can accept. It depends combinationally on `cdb_grant` through the advance chain. An issue is accepted when `issue_valid && issue_ready`.
  - In the accept cycle, `fu_done_valid` = 1 and `fu_done_id` = `rs_id`, combinationally. This lets the RS free the entry at the same edge.
  - In all other cycles, `fu_done_valid` = 0 and `fu_done_id` = 0.
- **Squash window** (circular; b = `branch_rob_tag`, t = `rob_tail`). A tag x is squashed if:
  - when b ≤ t: b < x ≤ t;
  - otherwise: x > b or x ≤ t.
- **Squash effect.** While `mispredict` = 1, every stage whose tag is in the window has `valid` cleared at the edge. Squash has priority over advance.
  - An issue accepted in the same cycle whose tag is in the window still completes the handshake and fires `fu_done_valid`, but enters stage 0 invalid.
- **Output masking.** `done_valid` = last-stage `valid` and not (`mispredict` and last tag in window). A squashed result is never presented.
- **Ordering.** Results leave in issue order. Nothing is dropped or duplicated except through squash.

## Timing
- **Reset.** `reset_n` low clears all stage registers (valid, tag, acc, operands) to 0 immediately. While in reset and after release:
  - `issue_ready` = 1;
  - `fu_done_valid` = 0, `fu_done_id` = 0;
  - `done_valid` = 0, `done_value` = 0, `done_rob_tag` = 0.
- **Reset mid-operation.** In-flight results are discarded. No output fires until a new issue is accepted.
- **Latency.** An issue accepted at edge N produces `done_valid` = 1 in the cycle following edge N+STAGES-1, provided there are no stalls. Every stall cycle adds one cycle.
- **Throughput.** One issue per cycle when `cdb_grant` stays high or the pipe has bubbles.
- **Full pipe.** With all STAGES stages valid and `cdb_grant` = 0, `issue_ready` = 0. If `cdb_grant` = 1 in that state, `issue_ready` = 1 in the same cycle.
- **Output hold.** `done_value` and `done_rob_tag` stay stable while `done_valid` = 1 and `cdb_grant` = 0.

## Test plan
- **Basic latency.** Reset, then issue MUL 7×6, tag 3, `rs_id` 5, with `cdb_grant` tied to 1.
  - Required: `fu_done_valid` = 1 with `fu_done_id` = 5 in the issue cycle.
  - Required: `done_value` = 42, `done_rob_tag` = 3, appearing 4 cycles later.
- **Function coverage.** Check each upper-half and signed variant:
  - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MUL 0x80000000 × 2 → 0x00000000.
- **Backpressure.** Issue tags 1–6 back-to-back while `cdb_grant` = 0 for the first 7 cycles, then 1.
  - Required: `issue_ready` drops after 4 accepts.
  - Required: results 1–6 appear in order, each held stable until granted.
- **Squash, no wrap.** In-flight tags 4, 6, 9; `mispredict` with b = 5, t = 9.
  - Required: only tag 4 reaches the CDB.
  - Required: an issue with tag 7 in the same cycle fires `fu_done_valid` but produces no result.
- **Squash, wrap-around.** 16-entry ROB; in-flight tags 13, 15, 0, 2; b = 14, t = 2.
  - Required: only tag 13 survives.
- **Reset mid-operation.** Pull `reset_n` low asynchronously, mid-cycle, with 3 results in flight.
  - Required: `done_valid` = 0 immediately and all outputs = 0.
  - Required: after release, a new MUL 3×3 returns 9 with nominal latency.
